// File: rtl/adder_seq_ctrl_if.sv
// Handshake and operand bus between a controller and the nibble-serial adder sequencer.
interface adder_seq_ctrl_if #(
    parameter int unsigned NIBBLES = 4
);
    localparam int unsigned W = 4 * NIBBLES;

    logic         start;
    logic         sub;
    logic         cin;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output start, sub, cin, op_a, op_b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, cin, op_a, op_b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/adder_4bit.sv
// 4-bit ripple-carry adder slice.
module adder_4bit (
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    input  logic       carry_in,
    output logic [3:0] out,
    output logic       carry_out
);
    // Ripple the carry through the four bit positions.
    always_comb begin
        logic c;
        c   = carry_in;
        out = '0;
        for (int i = 0; i < 4; i++) begin
            out[i] = in_a[i] ^ in_b[i] ^ c;
            c      = (in_a[i] & in_b[i]) | (c & (in_a[i] ^ in_b[i]));
        end
        carry_out = c;
    end
endmodule

// File: rtl/adder_seq_ctrl.sv
// Wide add/subtract sequencer: one adder_4bit slice reused LSB-first, one nibble per clock,
// with the inter-nibble carry held in a register.
module adder_seq_ctrl #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    adder_seq_ctrl_if.slave   bus
);
    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(NIBBLES - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                    state_q, state_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic                      carry_q, carry_d;
    logic [NIBBLES-1:0][3:0]   a_q, a_d;
    logic [NIBBLES-1:0][3:0]   b_q, b_d;
    logic [NIBBLES-1:0][3:0]   res_q, res_d;
    logic [W-1:0]              sum_q, sum_d;
    logic                      cout_q, cout_d;
    logic                      ovf_q, ovf_d;
    logic                      done_q, done_d;

    logic [3:0]                nib_out;
    logic                      nib_cout;

    adder_4bit u_slice (
        .in_a      (a_q[idx_q]),
        .in_b      (b_q[idx_q]),
        .carry_in  (carry_q),
        .out       (nib_out),
        .carry_out (nib_cout)
    );

    // State and datapath registers; reset clears everything including the visible result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    // Next-state: accept an operation in idle, step one nibble per cycle while running.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    a_d     = bus.op_a;
                    // Subtraction is A + ~B + 1: invert B once here, force carry-in to 1.
                    b_d     = bus.sub ? ~bus.op_b : bus.op_b;
                    carry_d = bus.sub ? 1'b1 : bus.cin;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                res_d[idx_q] = nib_out;
                carry_d      = nib_cout;
                if (idx_q == LastIdx) begin
                    sum_d   = res_d;
                    cout_d  = nib_cout;
                    // Signed overflow against the effective (possibly inverted) B operand.
                    ovf_d   = (a_q[NIBBLES-1][3] == b_q[NIBBLES-1][3]) &&
                              (nib_out[3] != a_q[NIBBLES-1][3]);
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.busy = (state_q == StRun);
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule
